// File: rtl/bayer_frame_capture.sv
// Bayer 2x2 quad to RGB frame capturer: address generation, AGC channel sums, overflow and short-frame flags.
// Optional macro BAYER_G_AVG_EN: green = rounded mean of both quad greens instead of the even-row green.
module bayer_frame_capture #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int PIX_W   = 12,
  parameter int CH_W    = 8,
  parameter int ADDR_W  = 20,
  parameter int SUM_W   = CH_W + $clog2(FRAME_W * FRAME_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              grab_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              href,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*CH_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              grab_done,
  output logic              overflow,
  output logic              short_frame,
  output logic [SUM_W-1:0]  sum_r,
  output logic [SUM_W-1:0]  sum_g,
  output logic [SUM_W-1:0]  sum_b,
  output logic [1:0]        dbg_state
);
  localparam int NPIX    = FRAME_W * FRAME_H;
  localparam int COL_MAX = 2 * FRAME_W;
  localparam int ROW_MAX = 2 * FRAME_H;
  localparam int COL_W   = $clog2(COL_MAX + 1);
  localparam int ROW_W   = $clog2(ROW_MAX + 1);
  localparam int IDX_W   = $clog2(NPIX + 1);
  localparam int LB_AW   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              vsync_q, href_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  slot_q, slot_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CH_W-1:0]   g1_q, g1_d, b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [4*CH_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [SUM_W-1:0]  sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic              overflow_q, overflow_d, short_q, short_d;

  logic [2*CH_W-1:0] lb_mem [FRAME_W];
  logic [2*CH_W-1:0] lb_rd;
  logic [LB_AW-1:0]  lb_idx;
  logic              lb_we;
  logic [CH_W-1:0]   ch, lb_g, lb_r, g_val;
  logic              vsync_rise, vsync_fall, href_fall;
  logic              take, quad_done, can_load, frame_full;
  logic              unused_bits;

  assign ch         = pix_data[PIX_W-1 -: CH_W];
  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign href_fall  = ~href & href_q;
  assign take       = (state_q == S_CAPTURE) && pix_valid && href &&
                      (col_q < COL_W'(COL_MAX)) && (row_q < ROW_W'(ROW_MAX));
  assign quad_done  = take && row_q[0] && col_q[0];
  assign lb_idx     = LB_AW'(col_q >> 1);
  assign lb_rd      = lb_mem[lb_idx];
  assign lb_g       = lb_rd[2*CH_W-1:CH_W];
  assign lb_r       = lb_rd[CH_W-1:0];
  assign unused_bits = ^pix_data;

  // Handshake: a word moves on every edge where out_valid && out_ready; while
  // out_valid && !out_ready the word and address hold; the register may reload
  // on the same edge it is accepted.
  assign can_load   = !out_valid_q || out_ready;
  assign frame_full = (slot_q == IDX_W'(NPIX)) && can_load;

`ifdef BAYER_G_AVG_EN
  logic [CH_W:0] g_sum;
  assign g_sum = {1'b0, lb_g} + {1'b0, ch} + {{CH_W{1'b0}}, 1'b1};
  assign g_val = g_sum[CH_W:1];
`else
  assign g_val = lb_g;
`endif

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [CH_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - CH_W){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    if (grab_start) begin
      state_d = S_WAIT_SOF;
    end else begin
      case (state_q)
        S_WAIT_SOF: if (vsync_rise) state_d = S_CAPTURE;
        S_CAPTURE:  if (vsync_fall || frame_full) state_d = S_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    slot_d      = slot_q;
    base_d      = base_q;
    g1_d        = g1_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    sum_r_d     = sum_r_q;
    sum_g_d     = sum_g_q;
    sum_b_d     = sum_b_q;
    overflow_d  = overflow_q;
    short_d     = short_q;
    lb_we       = 1'b0;
    if (grab_start) begin
      col_d       = '0;
      row_d       = '0;
      slot_d      = '0;
      base_d      = base_addr;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_addr_d  = '0;
      sum_r_d     = '0;
      sum_g_d     = '0;
      sum_b_d     = '0;
      overflow_d  = 1'b0;
      short_d     = 1'b0;
    end else begin
      if (href_fall) col_d = '0;
      else if (pix_valid && href && col_q != COL_W'(COL_MAX)) col_d = col_q + 1'b1;
      if (state_q == S_CAPTURE && href_fall && row_q != ROW_W'(ROW_MAX)) row_d = row_q + 1'b1;
      if (state_q == S_WAIT_SOF && vsync_rise) begin
        col_d = '0;
        row_d = '0;
      end
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      // Even rows park G1 until R arrives so the line buffer takes one write per quad.
      if (take && !row_q[0]) begin
        if (!col_q[0]) g1_d = ch;
        else lb_we = 1'b1;
      end
      if (take && row_q[0] && !col_q[0]) b_d = ch;
      if (quad_done) begin
        slot_d = slot_q + 1'b1;
        if (can_load) begin
          out_valid_d = 1'b1;
          out_data_d  = {b_q, {CH_W{1'b0}}, g_val, lb_r};
          out_addr_d  = base_q + ADDR_W'(slot_q);
          sum_r_d     = sat_add(sum_r_q, lb_r);
          sum_g_d     = sat_add(sum_g_q, g_val);
          sum_b_d     = sat_add(sum_b_q, b_q);
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (state_q == S_CAPTURE && vsync_fall && slot_q != IDX_W'(NPIX)) short_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      slot_q      <= '0;
      base_q      <= '0;
      g1_q        <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      sum_r_q     <= '0;
      sum_g_q     <= '0;
      sum_b_q     <= '0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      href_q      <= href;
      col_q       <= col_d;
      row_q       <= row_d;
      slot_q      <= slot_d;
      base_q      <= base_d;
      g1_q        <= g1_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      sum_r_q     <= sum_r_d;
      sum_g_q     <= sum_g_d;
      sum_b_q     <= sum_b_d;
      overflow_q  <= overflow_d;
      short_q     <= short_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_idx] <= {g1_q, ch};
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign busy        = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE);
  assign grab_done   = (state_q == S_DONE);
  assign overflow    = overflow_q;
  assign short_frame = short_q;
  assign sum_r       = sum_r_q;
  assign sum_g       = sum_g_q;
  assign sum_b       = sum_b_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_bayer_frame_capture.sv
// Directed bench for bayer_frame_capture on a 4x2 output frame (8x4 sensor samples),
// with a second instance using a narrow sum width to show saturation.
module tb_bayer_frame_capture;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int PW = 12;
  localparam int CW = 8;
  localparam int AW = 20;
  localparam int SW = CW + $clog2(FW * FH);
  localparam int SW_SAT = 9;
  localparam int DW = AW + 4 * CW;
`ifdef BAYER_G_AVG_EN
  localparam logic [7:0] G_EXP = 8'h19;
`else
  localparam logic [7:0] G_EXP = 8'h10;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic grab_start = 1'b0;
  logic href = 1'b0;
  logic vsync = 1'b0;
  logic pix_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [PW-1:0] pix_data = '0;

  logic          out_valid, busy, grab_done, overflow, short_frame;
  logic [4*CW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [SW-1:0] sum_r, sum_g, sum_b;
  logic [1:0]    dbg_state;

  logic          s_out_valid, s_busy, s_grab_done, s_overflow, s_short_frame;
  logic [4*CW-1:0] s_out_data;
  logic [AW-1:0] s_out_addr;
  logic [SW_SAT-1:0] s_sum_r, s_sum_g, s_sum_b;
  logic [1:0]    s_dbg_state;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int er, eg, eb;

  always #5 clk = ~clk;

  bayer_frame_capture #(.FRAME_W(FW), .FRAME_H(FH), .PIX_W(PW), .CH_W(CW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .grab_start(grab_start), .base_addr(base_addr),
    .href(href), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .grab_done(grab_done), .overflow(overflow), .short_frame(short_frame),
    .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b), .dbg_state(dbg_state)
  );

  bayer_frame_capture #(.FRAME_W(FW), .FRAME_H(FH), .PIX_W(PW), .CH_W(CW), .ADDR_W(AW),
                        .SUM_W(SW_SAT)) u_sat (
    .clk(clk), .reset_n(reset_n), .grab_start(grab_start), .base_addr(base_addr),
    .href(href), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_addr(s_out_addr),
    .busy(s_busy), .grab_done(s_grab_done), .overflow(s_overflow), .short_frame(s_short_frame),
    .sum_r(s_sum_r), .sum_g(s_sum_g), .sum_b(s_sum_b), .dbg_state(s_dbg_state)
  );

  // Monitor: record transfers and check that a stalled word holds still.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_word = '0;
  always @(negedge clk) begin
    if (stall_q && out_valid) begin
      n_checks++;
      if ({out_addr, out_data} !== stall_word) begin
        n_errors++;
        $display("FAIL stall_hold: got %h, required %h", {out_addr, out_data}, stall_word);
      end
    end
    stall_q    = out_valid && !out_ready;
    stall_word = {out_addr, out_data};
    if (out_valid && out_ready) got_q.push_back({out_addr, out_data});
  end

  function automatic logic [PW-1:0] samp(input int mode, input int r, input int c);
    logic [7:0] ch;
    logic [PW-1:0] v;
    if (mode == 1) begin
      v = 12'hFFF;
    end else if (mode == 2) begin
      case ({r[0], c[0]})
        2'b00:   ch = 8'h10;
        2'b01:   ch = 8'h33;
        2'b10:   ch = 8'h44;
        default: ch = 8'h21;
      endcase
      v = {ch, 4'h5};
    end else begin
      ch = 8'((r * 40 + c * 7 + 3) & 255);
      v = {ch, 4'(c)};
    end
    return v;
  endfunction

  function automatic logic [4*CW-1:0] exp_pix(input int mode, input int x, input int y);
    logic [PW-1:0] s;
    logic [CW-1:0] g1, r, b, g2, g;
    s = samp(mode, 2 * y, 2 * x);         g1 = s[PW-1 -: CW];
    s = samp(mode, 2 * y, 2 * x + 1);     r  = s[PW-1 -: CW];
    s = samp(mode, 2 * y + 1, 2 * x);     b  = s[PW-1 -: CW];
    s = samp(mode, 2 * y + 1, 2 * x + 1); g2 = s[PW-1 -: CW];
`ifdef BAYER_G_AVG_EN
    begin
      logic [CW:0] gs;
      gs = {1'b0, g1} + {1'b0, g2} + 9'd1;
      g = gs[CW:1];
    end
`else
    g = g1;
    if (g2 === 'x) g = 'x;
`endif
    return {b, 8'h00, g, r};
  endfunction

  task automatic build_exp(input int mode, input logic [AW-1:0] base, input int nq,
                           input int skip_lo, input int skip_hi);
    logic [4*CW-1:0] p;
    exp_q.delete();
    er = 0; eg = 0; eb = 0;
    for (int q = 0; q < nq; q++) begin
      if (q < skip_lo || q > skip_hi) begin
        p = exp_pix(mode, q % FW, q / FW);
        exp_q.push_back({base + AW'(q), p});
        er += int'(p[7:0]);
        eg += int'(p[15:8]);
        eb += int'(p[31:24]);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(input logic [AW-1:0] b);
    base_addr = b;
    grab_start = 1'b1;
    cyc();
    grab_start = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_rows(input int r0, input int nrows, input int mode, input int low_row);
    for (int r = r0; r < r0 + nrows; r++) begin
      out_ready = (r != low_row);
      href = 1'b1;
      for (int c = 0; c < 2 * FW; c++) begin
        pix_valid = 1'b1;
        pix_data = samp(mode, r, c);
        cyc();
      end
      href = 1'b0;
      pix_valid = 1'b0;
      cyc();
      out_ready = 1'b1;
      cyc();
      cyc();
    end
  endtask

  task automatic test_reset();
    cyc();
    n_checks++;
    if ({out_valid, busy, grab_done, overflow, short_frame} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {out_valid, busy, grab_done, overflow, short_frame});
    end
    n_checks++;
    if (out_data !== '0 || out_addr !== '0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_regs: data=%h addr=%h state=%0d, required 0/0/0", out_data, out_addr, dbg_state);
    end
    n_checks++;
    if (sum_r !== '0 || sum_g !== '0 || sum_b !== '0) begin
      n_errors++;
      $display("FAIL reset_sums: got %h %h %h, required 0", sum_r, sum_g, sum_b);
    end
    reset_n = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy=%b state=%0d, required 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_frame();
    grab(20'h00100);
    n_checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      n_errors++;
      $display("FAIL frame_arm: busy=%b state=%0d, required 1/1", busy, dbg_state);
    end
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2 * FH, 0, -1);
    for (int i = 0; i < 100 && grab_done !== 1'b1; i++) cyc();
    n_checks++;
    if (grab_done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_done: grab_done=%b busy=%b, required 1/0", grab_done, busy);
    end
    vsync = 1'b0; cyc();
    build_exp(0, 20'h00100, FW * FH, -1, -1);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL frame_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL frame_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || short_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_flags: overflow=%b short=%b, required 0/0", overflow, short_frame);
    end
    n_checks++;
    if (sum_r !== SW'(er) || sum_g !== SW'(eg) || sum_b !== SW'(eb)) begin
      n_errors++;
      $display("FAIL frame_sums: got %0d %0d %0d, required %0d %0d %0d", sum_r, sum_g, sum_b, er, eg, eb);
    end
  endtask

  task automatic test_overflow();
    grab(20'h00100);
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2 * FH, 0, 1);
    for (int i = 0; i < 100 && grab_done !== 1'b1; i++) cyc();
    vsync = 1'b0; cyc();
    build_exp(0, 20'h00100, FW * FH, 1, 3);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL ovf_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || short_frame !== 1'b0 || grab_done !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_flags: overflow=%b short=%b done=%b, required 1/0/1", overflow, short_frame, grab_done);
    end
    n_checks++;
    if (sum_r !== SW'(er) || sum_g !== SW'(eg) || sum_b !== SW'(eb)) begin
      n_errors++;
      $display("FAIL ovf_sums: got %0d %0d %0d, required %0d %0d %0d", sum_r, sum_g, sum_b, er, eg, eb);
    end
  endtask

  task automatic test_short_frame();
    grab(20'h00300);
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2, 0, -1);
    vsync = 1'b0; cyc();
    n_checks++;
    if (grab_done !== 1'b1 || short_frame !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL short_flags: done=%b short=%b busy=%b, required 1/1/0", grab_done, short_frame, busy);
    end
    build_exp(0, 20'h00300, FW, -1, -1);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL short_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL short_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_restart();
    grab(20'h00100);
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2, 0, -1);
    build_exp(0, 20'h00100, FW, -1, -1);
    n_checks++;
    if (sum_r !== SW'(er)) begin
      n_errors++;
      $display("FAIL restart_pre_sum: got %0d, required %0d", sum_r, er);
    end
    grab(20'h00200);
    n_checks++;
    if (sum_r !== '0 || sum_g !== '0 || sum_b !== '0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_clear: sums %0d %0d %0d valid=%b, required 0", sum_r, sum_g, sum_b, out_valid);
    end
    n_checks++;
    if (dbg_state !== 2'd1 || grab_done !== 1'b0 || overflow !== 1'b0 || short_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_state: state=%0d done=%b ovf=%b short=%b, required 1/0/0/0",
               dbg_state, grab_done, overflow, short_frame);
    end
    send_rows(2, 2, 0, -1);
    vsync = 1'b0; cyc(); cyc();
    n_checks++;
    if (got_q.size() !== 0 || short_frame !== 1'b0 || dbg_state !== 2'd1) begin
      n_errors++;
      $display("FAIL restart_wait: transfers=%0d short=%b state=%0d, required 0/0/1",
               got_q.size(), short_frame, dbg_state);
    end
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2 * FH, 0, -1);
    for (int i = 0; i < 100 && grab_done !== 1'b1; i++) cyc();
    vsync = 1'b0; cyc();
    build_exp(0, 20'h00200, FW * FH, -1, -1);
    n_checks++;
    if (got_q.size() !== exp_q.size() || grab_done !== 1'b1) begin
      n_errors++;
      $display("FAIL restart_count: got %0d transfers done=%b, required %0d/1", got_q.size(), grab_done, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL restart_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] w;
    grab(20'h00000);
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2 * FH, 1, -1);
    for (int i = 0; i < 100 && grab_done !== 1'b1; i++) cyc();
    vsync = 1'b0; cyc();
    n_checks++;
    if (got_q.size() !== FW * FH) begin
      n_errors++;
      $display("FAIL sat_count: got %0d transfers, required %0d", got_q.size(), FW * FH);
    end else begin
      w = got_q[FW * FH - 1];
      if (w[31:0] !== 32'hFF00FFFF || w[DW-1:32] !== 20'h00007) begin
        n_errors++;
        $display("FAIL sat_word: got %h, required 00007ff00ffff", w);
      end
    end
    n_checks++;
    if (sum_r !== 11'd2040 || sum_g !== 11'd2040 || sum_b !== 11'd2040) begin
      n_errors++;
      $display("FAIL sat_sums: got %0d %0d %0d, required 2040", sum_r, sum_g, sum_b);
    end
    n_checks++;
    if (s_sum_r !== 9'h1FF || s_sum_g !== 9'h1FF || s_sum_b !== 9'h1FF) begin
      n_errors++;
      $display("FAIL sat_clamp: got %h %h %h, required 1ff", s_sum_r, s_sum_g, s_sum_b);
    end
  endtask

  task automatic test_g_avg();
    logic [DW-1:0] w;
    grab(20'h00040);
    vsync = 1'b1; cyc(); cyc();
    send_rows(0, 2, 2, -1);
    vsync = 1'b0; cyc();
    n_checks++;
    if (got_q.size() == 0) begin
      n_errors++;
      $display("FAIL g_avg_none: got 0 transfers, required 4");
    end else begin
      w = got_q[0];
      if (w[15:8] !== G_EXP || w[7:0] !== 8'h33 || w[31:24] !== 8'h44 || w[DW-1:32] !== 20'h00040) begin
        n_errors++;
        $display("FAIL g_avg: got %h, required G=%h R=33 B=44 addr=00040", w, G_EXP);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_short_frame();
    test_restart();
    test_saturation();
    test_g_avg();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
